// File: rtl/usb_stream_pkg.sv
// ---------------------------------------------------------------------------
// usb_stream_pkg
//   Shared constants and types for the receive-side symbol path that sits
//   between the UART receiver and the convolutional decoder.
//   Contents:
//     BYTE_W         width of a received UART byte
//     SYM_W          width of one encoded symbol
//     SYMS_PER_BYTE  symbols carried by one byte
//     IDX_W          width of the symbol index inside a byte
//     unpack_state_t serializer state (IDLE: no byte held, SHIFT: byte held)
// ---------------------------------------------------------------------------
package usb_stream_pkg;

   localparam int BYTE_W        = 8;
   localparam int SYM_W         = 2;
   localparam int SYMS_PER_BYTE = BYTE_W / SYM_W;
   localparam int IDX_W         = $clog2(SYMS_PER_BYTE);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } unpack_state_t;

endpackage

// File: rtl/byte_fifo.sv
// ---------------------------------------------------------------------------
// byte_fifo
//   Small synchronous byte FIFO. Pointers carry one extra wrap bit, so full
//   and empty are told apart without a separate counter: the pointers are
//   equal when empty and differ only in the wrap bit when full.
//   A push while full is ignored here; the parent reports the drop.
//   A clear empties the FIFO and overrides any same-cycle push or pop.
//   Ports:
//     clk          system clock
//     rst_n        asynchronous active-low reset
//     clear_i      synchronous clear of both pointers
//     push_i       write push_data_i when not full
//     push_data_i  byte to store
//     pop_i        discard the head entry when not empty
//     pop_data_o   head entry (valid while !empty_o)
//     full_o       DEPTH entries stored
//     empty_o      no entries stored
//     level_o      number of entries stored
// ---------------------------------------------------------------------------
module byte_fifo
   import usb_stream_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear_i,
   input  logic                     push_i,
   input  logic [BYTE_W-1:0]        push_data_i,
   input  logic                     pop_i,
   output logic [BYTE_W-1:0]        pop_data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int AW = $clog2(DEPTH);

   logic [BYTE_W-1:0] mem_q [DEPTH];
   logic [AW:0]       wr_ptr_q, wr_ptr_d;
   logic [AW:0]       rd_ptr_q, rd_ptr_d;
   logic              push_ok;
   logic              pop_ok;

   // Status flags come straight from the pointers; full is judged on the
   // current pointers, so a pop in the same cycle does not make room.
   always_comb begin
      full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      empty_o    = (wr_ptr_q == rd_ptr_q);
      level_o    = wr_ptr_q - rd_ptr_q;
      pop_data_o = mem_q[rd_ptr_q[AW-1:0]];
   end

   // Pointer advance; clear wins over everything else.
   always_comb begin
      push_ok  = push_i && !full_o && !clear_i;
      pop_ok   = pop_i && !empty_o && !clear_i;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (clear_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push_ok) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
         end
         if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
         end
      end
   end

   // Pointer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
      end
   end

endmodule

// File: rtl/rx_symbol_unpacker.sv
// ---------------------------------------------------------------------------
// rx_symbol_unpacker
//   Buffers received UART bytes in a byte_fifo and splits each byte into
//   four 2-bit encoded symbols, offered to the decoder over valid/ready.
//   Bytes have no backpressure: a byte arriving while the FIFO is full is
//   dropped and the sticky overflow flag is set.
//   Optional feature macro: SYM_COUNT_EN adds the sym_count output, a
//   16-bit wrapping count of symbols transferred since reset or flush.
//   Parameters:
//     DEPTH      FIFO depth in bytes (power of 2, >= 2)
//     MSB_FIRST  nonzero: emit byte[7:6] first; zero: emit byte[1:0] first
//   Ports:
//     clk         system clock
//     rst_n       asynchronous active-low reset
//     byte_valid  one-cycle strobe qualifying byte_data
//     byte_data   received byte
//     flush       synchronous clear of FIFO, serializer and overflow
//     sym_valid   sym_data holds a symbol
//     sym_data    encoded symbol
//     sym_ready   decoder accepts the symbol this cycle
//     sym_last    sym_data is the fourth symbol of its byte
//     sym_count   symbols transferred (SYM_COUNT_EN only)
//     fifo_level  bytes waiting in the FIFO (excludes the byte being sent)
//     overflow    sticky: a byte was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module rx_symbol_unpacker
   import usb_stream_pkg::*;
#(
   parameter int DEPTH     = 4,
   parameter int MSB_FIRST = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     byte_valid,
   input  logic [BYTE_W-1:0]        byte_data,
   input  logic                     flush,
   output logic                     sym_valid,
   output logic [SYM_W-1:0]         sym_data,
   input  logic                     sym_ready,
   output logic                     sym_last,
`ifdef SYM_COUNT_EN
   output logic [15:0]              sym_count,
`endif
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     overflow
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SYMS_PER_BYTE - 1);

   unpack_state_t     state_q, state_d;
   logic [BYTE_W-1:0] shift_q, shift_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              overflow_q;
   logic              fifo_pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [BYTE_W-1:0] fifo_rdata;
   logic              xfer;
   logic              refill;

   byte_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear_i     (flush),
      .push_i      (byte_valid),
      .push_data_i (byte_data),
      .pop_i       (fifo_pop),
      .pop_data_o  (fifo_rdata),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .level_o     (fifo_level)
   );

   // A symbol moves whenever one is offered and the decoder takes it. A
   // refill happens when nothing is held, or when the last symbol of the
   // held byte leaves; taking the next byte on that same edge avoids a bubble.
   always_comb begin
      xfer   = (state_q == SHIFT) && sym_ready;
      refill = !flush && !fifo_empty &&
               ((state_q == IDLE) || (xfer && (idx_q == LAST_IDX)));
   end

   // Serializer state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: flush forces IDLE; a finished byte with nothing queued
   // returns to IDLE, otherwise a byte is held in SHIFT.
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (!fifo_empty) begin
                  state_d = SHIFT;
               end
            end
            SHIFT: begin
               if (xfer && (idx_q == LAST_IDX) && fifo_empty) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Outputs: the current symbol always sits at the emitting end of the
   // shift register, so it holds steady until it is accepted.
   always_comb begin
      sym_valid = (state_q == SHIFT);
      sym_last  = (state_q == SHIFT) && (idx_q == LAST_IDX);
      sym_data  = '0;
      if (state_q == SHIFT) begin
         sym_data = (MSB_FIRST != 0) ? shift_q[BYTE_W-1 -: SYM_W]
                                     : shift_q[SYM_W-1:0];
      end
   end

   // Shift register and symbol index: load on refill, shift toward the
   // emitting end on every other transfer, clear on flush or end of data.
   always_comb begin
      shift_d  = shift_q;
      idx_d    = idx_q;
      fifo_pop = refill;
      if (flush) begin
         shift_d = '0;
         idx_d   = '0;
      end else if (refill) begin
         shift_d = fifo_rdata;
         idx_d   = '0;
      end else if (xfer) begin
         if (idx_q == LAST_IDX) begin
            shift_d = '0;
            idx_d   = '0;
         end else begin
            idx_d   = idx_q + IDX_W'(1);
            shift_d = (MSB_FIRST != 0) ? (shift_q << SYM_W)
                                       : (shift_q >> SYM_W);
         end
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q <= '0;
         idx_q   <= '0;
      end else begin
         shift_q <= shift_d;
         idx_q   <= idx_d;
      end
   end

   // Sticky drop flag; a byte offered during flush is not a drop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_q <= 1'b0;
      end else if (flush) begin
         overflow_q <= 1'b0;
      end else if (byte_valid && fifo_full) begin
         overflow_q <= 1'b1;
      end
   end

   assign overflow = overflow_q;

`ifdef SYM_COUNT_EN
   logic [15:0] count_q;

   // Counts accepted symbols; wraps naturally at 16 bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (flush) begin
         count_q <= '0;
      end else if (xfer) begin
         count_q <= count_q + 16'd1;
      end
   end

   assign sym_count = count_q;
`endif

endmodule
